uart_hex_tx: RTL and testbench



---
 rtl/uart_hex_tx.sv | 177 +++++++++++++++++
 tb/tb_uart_hex_tx.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_hex_tx.sv
// uart_hex_tx: prints a DATA_W-bit word as uppercase ASCII hex digits (MSB nibble
// first) followed by a line feed, each character sent as an 8N1 UART frame.
// Optional feature macro: UART_HEX_SKIP_LEADING_ZEROS_EN drops leading zero digits
// (at least one digit is always printed).
module uart_hex_tx #(
  parameter int CLKS_PER_BIT = 2604,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] value_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic              ser_tx
);

  localparam int NDIG   = DATA_W / 4;
  localparam int DIG_W  = $clog2(NDIG + 1);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [DIG_W-1:0]  DIG_INIT  = DIG_W'(NDIG);
  localparam logic [DIG_W-1:0]  DIG_ONE   = DIG_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef UART_HEX_SKIP_LEADING_ZEROS_EN
    ,
    S_SKIP
`endif
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DIG_W-1:0]    digits_q, digits_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_q, bit_d;
  logic                ser_q, ser_d;

  logic [3:0]          nib;
  logic [7:0]          char_c;
  logic                baud_done;

  // Current character: a hex digit while digits remain, otherwise the closing LF.
  always_comb begin
    nib = shift_q[DATA_W-1 -: 4];
    if (digits_q != '0) begin
      if (nib < 4'd10) begin
        char_c = {4'h0, nib} + 8'h30;
      end else begin
        char_c = {4'h0, nib} + 8'h37;
      end
    end else begin
      char_c = 8'h0A;
    end
  end

  assign baud_done = (baud_q == BAUD_LAST);

  // Next-state logic: frame sequencing, baud/bit counting and the registered line value.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    digits_d = digits_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    ser_d    = ser_q;

    case (state_q)
      S_IDLE: begin
        ser_d  = 1'b1;
        baud_d = '0;
        bit_d  = '0;
        if (valid_i) begin
          shift_d  = value_i;
          digits_d = DIG_INIT;
`ifdef UART_HEX_SKIP_LEADING_ZEROS_EN
          state_d  = S_SKIP;
`else
          state_d  = S_START;
          ser_d    = 1'b0;
`endif
        end
      end

`ifdef UART_HEX_SKIP_LEADING_ZEROS_EN
      S_SKIP: begin
        if ((digits_q > DIG_ONE) && (nib == 4'h0)) begin
          shift_d  = shift_q << 4;
          digits_d = digits_q - DIG_ONE;
        end else begin
          state_d = S_START;
          ser_d   = 1'b0;
          baud_d  = '0;
        end
      end
`endif

      S_START: begin
        if (baud_done) begin
          state_d = S_DATA;
          baud_d  = '0;
          bit_d   = '0;
          ser_d   = char_c[0];
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end

      S_DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            ser_d   = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            ser_d = char_c[bit_q + 3'd1];
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end

      S_STOP: begin
        if (baud_done) begin
          baud_d = '0;
          if (digits_q == '0) begin
            state_d = S_IDLE;
            ser_d   = 1'b1;
          end else begin
            shift_d  = shift_q << 4;
            digits_d = digits_q - DIG_ONE;
            state_d  = S_START;
            ser_d    = 1'b0;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
        ser_d   = 1'b1;
      end
    endcase
  end

  // State register with synchronous reset; reset abandons any partial character.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      digits_q <= '0;
      baud_q   <= '0;
      bit_q    <= '0;
      ser_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      digits_q <= digits_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      ser_q    <= ser_d;
    end
  end

  assign ready_o = (state_q == S_IDLE);
  assign busy_o  = ~ready_o;
  assign ser_tx  = ser_q;

endmodule

// File: tb/tb_uart_hex_tx.sv
// tb_uart_hex_tx: drives random and directed words into uart_hex_tx, decodes the
// serial line with a behavioural UART receiver and scoreboards each received line
// against a hex-string model. Honours UART_HEX_SKIP_LEADING_ZEROS_EN if defined.
module tb_uart_hex_tx;

  localparam int C  = 4;
  localparam int DW = 16;
  localparam int ND = DW / 4;

  logic          clk     = 1'b0;
  logic          rst     = 1'b1;
  logic [DW-1:0] value_i = '0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic          busy_o;
  logic          ser_tx;

  int    n_checks   = 0;
  int    n_fail     = 0;
  int    accept_cnt = 0;
  int    low_cnt    = 0;
  string exp_q[$];
  int    len_q[$];

  uart_hex_tx #(.CLKS_PER_BIT(C), .DATA_W(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .value_i (value_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .busy_o  (busy_o),
    .ser_tx  (ser_tx)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Reference model: the text line (without LF) a word should print as.
  function automatic string hex_line(input logic [DW-1:0] v);
    string digits;
    string s;
    int    first;
    int    nibv;
    digits = "0123456789ABCDEF";
    s      = "";
    first  = ND - 1;
`ifdef UART_HEX_SKIP_LEADING_ZEROS_EN
    while (first > 0 && v[4*first +: 4] == 4'h0) first--;
`endif
    for (int i = first; i >= 0; i--) begin
      nibv = int'(v[4*i +: 4]);
      s = $sformatf("%s%c", s, digits[nibv]);
    end
    return s;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkLine(input string actual, input string expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL line: got \"%s\", expected \"%s\"", actual, expected);
    end
  endtask

  // Wait for ready, present one word for a single cycle, then drop valid.
  task automatic applyStimulus(input logic [DW-1:0] v);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!ready_o && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 3000) checkOutput("ready_timeout", 0, 1);
    valid_i = 1'b1;
    value_i = v;
    @(posedge clk); #1;
    valid_i = 1'b0;
    value_i = DW'($urandom);
  endtask

  task automatic rx_wait(input int n, output bit ab);
    ab = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (rst) ab = 1'b1;
    end
  endtask

  // Accept tracking, ready-low duration check and idle-line invariants, sampled on negedge.
  always @(negedge clk) begin
    int lo;
    int hi;
    string s;
    if (rst) begin
      low_cnt = 0;
      exp_q.delete();
      len_q.delete();
    end else begin
      checkOutput("busy_vs_ready", busy_o, !ready_o);
      if (ready_o) begin
        checkOutput("idle_line_high", ser_tx, 1);
        if (low_cnt > 0) begin
          if (len_q.size() == 0) begin
            checkOutput("ready_low_without_accept", low_cnt, 0);
          end else begin
            lo = len_q.pop_front();
`ifdef UART_HEX_SKIP_LEADING_ZEROS_EN
            hi = lo + ND;
`else
            hi = lo;
`endif
            n_checks++;
            if (low_cnt < lo || low_cnt > hi) begin
              n_fail++;
              $display("[TB] FAIL ready_low_cycles: got %0d, expected %0d..%0d", low_cnt, lo, hi);
            end
          end
        end
        low_cnt = 0;
        if (valid_i) begin
          s = hex_line(value_i);
          exp_q.push_back(s);
          len_q.push_back((s.len() + 1) * 10 * C);
          accept_cnt++;
        end
      end else begin
        low_cnt++;
      end
    end
  end

  // Behavioural 8N1 receiver: samples mid-bit, assembles lines and scoreboards them.
  initial begin : receiver
    string      line;
    logic [7:0] ch;
    logic       sb;
    bit         ab;
    bit         abort_any;
    line = "";
    forever begin
      @(negedge clk);
      if (rst) begin
        line = "";
      end else if (ser_tx == 1'b0) begin
        abort_any = 1'b0;
        rx_wait(C / 2, ab);
        abort_any |= ab;
        sb = ser_tx;
        for (int b = 0; b < 8; b++) begin
          rx_wait(C, ab);
          abort_any |= ab;
          ch[b] = ser_tx;
        end
        rx_wait(C, ab);
        abort_any |= ab;
        if (abort_any) begin
          line = "";
        end else begin
          checkOutput("start_bit", sb, 0);
          checkOutput("stop_bit", ser_tx, 1);
          if (ch == 8'h0A) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("[TB] FAIL unexpected_line: got \"%s\", expected none", line);
            end else begin
              checkLine(line, exp_q.pop_front());
            end
            line = "";
          end else begin
            line = $sformatf("%s%c", line, ch);
          end
        end
      end
    end
  end

  // Hard stop in case something wedges the run.
  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed and random stimulus sequence.
  initial begin : stimulus
    int base;
    int n;
    int edges;
    logic [DW-1:0] v;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_ready", ready_o, 1);
    checkOutput("reset_busy", busy_o, 0);
    checkOutput("reset_ser", ser_tx, 1);

    $display("[TB] basic word 0x1A2F");
    applyStimulus(16'h1A2F);
    applyStimulus(16'h00C3);
    applyStimulus(16'h0000);
    applyStimulus(16'hFFFF);

    $display("[TB] request while busy");
    applyStimulus(16'hABCD);
    repeat (10 * C + 5) @(posedge clk);
    #1 valid_i = 1'b1;
    value_i = 16'h1234;
    @(posedge clk); #1;
    valid_i = 1'b0;
    n = 0;
    while (!ready_o && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (100) @(posedge clk);
    #1;
    checkOutput("no_second_transfer_ready", ready_o, 1);
    checkOutput("no_second_transfer_queue", exp_q.size(), 0);

    $display("[TB] rst and valid together");
    @(posedge clk); #1;
    rst = 1'b1;
    valid_i = 1'b1;
    value_i = 16'h7777;
    @(posedge clk); #1;
    rst = 1'b0;
    valid_i = 1'b0;
    @(negedge clk);
    checkOutput("rst_beats_valid", ready_o, 1);

    $display("[TB] reset mid-frame");
    applyStimulus(16'h5A3C);
    repeat (20 * C + C + 3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("after_reset_ser", ser_tx, 1);
    checkOutput("after_reset_ready", ready_o, 1);
    edges = 0;
    repeat (60) begin
      @(negedge clk);
      if (ser_tx != 1'b1) edges++;
    end
    checkOutput("no_edges_after_reset", edges, 0);
    applyStimulus(16'h0001);

    $display("[TB] held valid");
    base = accept_cnt;
    n = 0;
    @(posedge clk); #1;
    valid_i = 1'b1;
    value_i = 16'h00FF;
    while (accept_cnt < base + 3 && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    valid_i = 1'b0;
    checkOutput("held_valid_accepts", accept_cnt - base, 3);

    $display("[TB] random words");
    for (int i = 0; i < 20; i++) begin
      v = DW'($urandom);
      if ($urandom_range(0, 3) == 0) v &= 16'h00FF;
      if ($urandom_range(0, 7) == 0) v &= 16'h000F;
      applyStimulus(v);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 60)) @(posedge clk);
        #1 valid_i = 1'b1;
        value_i = DW'($urandom);
        @(posedge clk); #1;
        valid_i = 1'b0;
      end
      repeat ($urandom_range(0, 5)) @(posedge clk);
    end

    n = 0;
    while ((exp_q.size() != 0 || !ready_o) && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (20) @(posedge clk);
    #1;
    checkOutput("drain_queue", exp_q.size(), 0);
    checkOutput("drain_ready", ready_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
